// File: rtl/riscv_dmem_mmio_if.sv
// Data-memory bus between the MEM stage and riscv_dmem_mmio,
// plus the console TX drain handshake.
interface riscv_dmem_mmio_if;
    logic [31:0] DataMemAddr;
    logic        DataMemRead;
    logic        DataMemWrite;
    logic [31:0] DataMemWData;
    logic [31:0] DataMemRData;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output DataMemAddr,
        output DataMemRead,
        output DataMemWrite,
        output DataMemWData,
        output tx_ready,
        input  DataMemRData,
        input  tx_valid,
        input  tx_data
    );

    modport slave (
        input  DataMemAddr,
        input  DataMemRead,
        input  DataMemWrite,
        input  DataMemWData,
        input  tx_ready,
        output DataMemRData,
        output tx_valid,
        output tx_data
    );
endinterface

// File: rtl/riscv_dmem_mmio.sv
// Data RAM plus MMIO window: console TX FIFO, cycle counter,
// compare timer. Reads are combinational, writes on the rising edge.
module riscv_dmem_mmio #(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic             CLK,
    input  logic             RST,
    riscv_dmem_mmio_if.slave bus,
    output logic             timer_irq
);
    localparam int RAW = $clog2(RAM_WORDS);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;
    localparam logic [FAW:0] FULL_CNT = (FAW+1)'(FIFO_DEPTH);

    logic [31:0] ram [RAM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [FAW-1:0] rd_ptr;
    logic [FAW-1:0] wr_ptr;
    logic [FAW:0]   count;
    logic           overflow;
    logic [31:0]    cycle;
    logic [31:0]    cmp;
    logic           enable;
    logic           irq_flag;

    logic           is_ram;
    logic           is_mmio;
    logic [2:0]     reg_off;
    logic [RAW-1:0] ram_idx;
    logic           ram_we;
    logic           mmio_we;
    logic           wr_tx;
    logic           wr_stat;
    logic           wr_cyc;
    logic           wr_cmp;
    logic           wr_ctrl;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;
    logic drop;
    logic tmr_hit;
    logic irq_clr;

    logic [31:0] status;
    logic [31:0] mmio_rd;
    logic [31:0] rdata;

    assign is_ram  = bus.DataMemAddr < RAM_BYTES;
    assign is_mmio = bus.DataMemAddr[31:5] == MMIO_BASE[31:5];
    assign reg_off = bus.DataMemAddr[4:2];
    assign ram_idx = bus.DataMemAddr[RAW+1:2];

    // A write sampled while reset is held is dropped, RAM included.
    assign ram_we  = bus.DataMemWrite && is_ram && RST;
    assign mmio_we = bus.DataMemWrite && is_mmio;
    assign wr_tx   = mmio_we && (reg_off == 3'd0);
    assign wr_stat = mmio_we && (reg_off == 3'd1);
    assign wr_cyc  = mmio_we && (reg_off == 3'd2);
    assign wr_cmp  = mmio_we && (reg_off == 3'd3);
    assign wr_ctrl = mmio_we && (reg_off == 3'd4);

    assign fifo_full  = count == FULL_CNT;
    assign fifo_empty = count == '0;
    assign pop        = !fifo_empty && bus.tx_ready;
    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    assign push       = wr_tx && (!fifo_full || pop);
    assign drop       = wr_tx && !push;

    assign tmr_hit = enable && (cycle == cmp);
    assign irq_clr = wr_ctrl && bus.DataMemWData[1];

    always_ff @(posedge CLK) begin
        if (ram_we) ram[ram_idx] <= bus.DataMemWData;
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= bus.DataMemWData[7:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (drop) overflow <= 1'b1;
            else if (wr_stat) overflow <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cycle    <= '0;
            cmp      <= '1;
            enable   <= 1'b0;
            irq_flag <= 1'b0;
        end else begin
            cycle <= wr_cyc ? bus.DataMemWData : cycle + 32'd1;
            if (wr_cmp) cmp <= bus.DataMemWData;
            if (wr_ctrl) enable <= bus.DataMemWData[0];
            if (tmr_hit) irq_flag <= 1'b1;
            else if (irq_clr) irq_flag <= 1'b0;
        end
    end

    assign timer_irq    = irq_flag;
    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

    always_comb begin
        status = '0;
        status[8 +: FAW+1] = count;
        status[2] = overflow;
        status[1] = fifo_empty;
        status[0] = fifo_full;
    end

    always_comb begin
        mmio_rd = '0;
        case (reg_off)
            3'd1:    mmio_rd = status;
            3'd2:    mmio_rd = cycle;
            3'd3:    mmio_rd = cmp;
            3'd4:    mmio_rd = {30'd0, irq_flag, enable};
            default: mmio_rd = '0;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (bus.DataMemRead) begin
            unique case (1'b1)
                is_ram:  rdata = ram[ram_idx];
                is_mmio: rdata = mmio_rd;
                default: rdata = '0;
            endcase
        end
    end

    assign bus.DataMemRData = rdata;
endmodule

// File: tb/tb_riscv_dmem_mmio.sv
// Self-checking bench for riscv_dmem_mmio: directed scenarios plus
// randomized RAM and FIFO traffic against a queue/array model.
module tb_riscv_dmem_mmio;
    localparam logic [31:0] TXD  = 32'h8000_0000;
    localparam logic [31:0] STAT = 32'h8000_0004;
    localparam logic [31:0] CYC  = 32'h8000_0008;
    localparam logic [31:0] CMPR = 32'h8000_000C;
    localparam logic [31:0] CTRL = 32'h8000_0010;
    localparam int DEPTH = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic timer_irq;
    int n_vec = 0;
    int n_err = 0;

    riscv_dmem_mmio_if bus ();

    riscv_dmem_mmio dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .timer_irq (timer_irq)
    );

    always #5 CLK = ~CLK;

    task automatic set_bus(input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        bus.DataMemRead  = rd;
        bus.DataMemWrite = wr;
        bus.DataMemAddr  = a;
        bus.DataMemWData = d;
    endtask

    task automatic next_cycle();
        @(negedge CLK);
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        next_cycle();
        set_bus(1'b0, 1'b1, a, d);
    endtask

    task automatic read_now(input logic [31:0] a, output logic [31:0] v);
        set_bus(1'b1, 1'b0, a, 32'h0);
        #1;
        v = bus.DataMemRData;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
        bus.tx_ready = 1'b0;
        RST = 1'b0;
        #1;
        n_vec++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid got %b exp 0", bus.tx_valid); end
        n_vec++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data got %h exp 00", bus.tx_data); end
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        set_bus(1'b0, 1'b0, CMPR, 32'h0);
        #1;
        n_vec++; if (bus.DataMemRData !== 32'h0) begin n_err++; $display("FAIL rst_rdata_noread got %h exp 0", bus.DataMemRData); end
        read_now(CYC, v);
        n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_cycle got %h exp 0", v); end
        read_now(STAT, v);
        n_vec++; if (v !== 32'h0000_0002) begin n_err++; $display("FAIL rst_status got %h exp 00000002", v); end
        read_now(CMPR, v);
        n_vec++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_cmp got %h exp ffffffff", v); end
        read_now(CTRL, v);
        n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_ctrl got %h exp 0", v); end
        n_vec++; if (timer_irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b exp 0", timer_irq); end
    endtask

    task automatic test_ram_directed();
        logic [31:0] v;
        write_reg(32'h10, 32'hDEAD_BEEF);
        next_cycle();
        read_now(32'h10, v);
        n_vec++; if (v !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_rd10 got %h exp deadbeef", v); end
        read_now(32'h13, v);
        n_vec++; if (v !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_rd13 got %h exp deadbeef", v); end
        read_now(32'h1000, v);
        n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL ram_unmapped got %h exp 0", v); end
        next_cycle();
        set_bus(1'b1, 1'b1, 32'h10, 32'h1234_5678);
        #1;
        n_vec++; if (bus.DataMemRData !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_rdw_old got %h exp deadbeef", bus.DataMemRData); end
        next_cycle();
        read_now(32'h10, v);
        n_vec++; if (v !== 32'h1234_5678) begin n_err++; $display("FAIL ram_rdw_new got %h exp 12345678", v); end
        write_reg(32'h20, 32'h1111_1111);
    endtask

    task automatic test_ram_random();
        logic [31:0] mdl [int];
        logic [31:0] v;
        logic [31:0] a;
        logic [31:0] d;
        int w;
        mdl[4] = 32'hDEAD_BEEF;
        mdl[8] = 32'h1111_1111;
        mdl.delete(4);
        mdl[4] = 32'h1234_5678;
        for (int i = 0; i < 40; i++) begin
            w = $urandom_range(9, 1023);
            a = (w * 4) + $urandom_range(0, 3);
            d = $urandom;
            write_reg(a, d);
            mdl[w] = d;
        end
        // Unmapped writes must not alias into RAM.
        for (int i = 0; i < 4; i++) begin
            write_reg(32'h1000 + ($urandom_range(0, 1023) * 4), $urandom);
        end
        next_cycle();
        foreach (mdl[k]) begin
            next_cycle();
            a = k * 4;
            read_now(a, v);
            n_vec++; if (v !== mdl[k]) begin n_err++; $display("FAIL ram_rand[%0d] got %h exp %h", k, v, mdl[k]); end
        end
        for (int i = 0; i < 4; i++) begin
            a = 32'h1000 + $urandom_range(0, 32'h7FFF_0000);
            read_now(a, v);
            n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL ram_unmapped_rand got %h exp 0 at %h", v, a); end
        end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] v;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) write_reg(TXD, 32'h41 + i);
        next_cycle();
        read_now(STAT, v);
        n_vec++; if (v !== 32'h0805) begin n_err++; $display("FAIL fifo_full_status got %h exp 00000805", v); end
        next_cycle();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cycle();
            #1;
            n_vec++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(8'h41 + i)) begin n_err++; $display("FAIL fifo_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.tx_valid, bus.tx_data, 8'(8'h41 + i)); end
        end
        next_cycle();
        #1;
        n_vec++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL fifo_drained_valid got %b exp 0", bus.tx_valid); end
        read_now(STAT, v);
        n_vec++; if (v !== 32'h0006) begin n_err++; $display("FAIL fifo_empty_ovf got %h exp 00000006", v); end
        write_reg(STAT, $urandom);
        next_cycle();
        read_now(STAT, v);
        n_vec++; if (v !== 32'h0002) begin n_err++; $display("FAIL fifo_ovf_clear got %h exp 00000002", v); end
        read_now(TXD, v);
        n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL txdata_read got %h exp 0", v); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] v;
        logic [7:0] exp_b [9];
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_reg(TXD, 32'h30 + i);
        next_cycle();
        set_bus(1'b0, 1'b1, TXD, 32'h5A);
        bus.tx_ready = 1'b1;
        #1;
        n_vec++; if (bus.tx_data !== 8'h30) begin n_err++; $display("FAIL pp_head got %h exp 30", bus.tx_data); end
        next_cycle();
        bus.tx_ready = 1'b0;
        read_now(STAT, v);
        n_vec++; if (v !== 32'h0801) begin n_err++; $display("FAIL pp_status got %h exp 00000801", v); end
        for (int i = 0; i < 7; i++) exp_b[i] = 8'(8'h31 + i);
        exp_b[7] = 8'h5A;
        next_cycle();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cycle();
            #1;
            n_vec++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_b[i]) begin n_err++; $display("FAIL pp_drain[%0d] got v=%b d=%h exp %h", i, bus.tx_valid, bus.tx_data, exp_b[i]); end
        end
        next_cycle();
        #1;
        n_vec++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL pp_end_valid got %b exp 0", bus.tx_valid); end
    endtask

    task automatic test_fifo_random();
        logic [7:0] q [$];
        logic ovf;
        logic push;
        logic rdy;
        logic [7:0] b;
        logic [31:0] v;
        logic [31:0] exp_s;
        ovf = 1'b0;
        for (int n = 0; n < 240; n++) begin
            next_cycle();
            push = $urandom_range(0, 2) != 0;
            rdy = (n < 120) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            b = 8'($urandom);
            if (push) set_bus(1'b0, 1'b1, TXD, {24'h0, b});
            bus.tx_ready = rdy;
            #1;
            n_vec++; if (bus.tx_valid !== (q.size() != 0)) begin n_err++; $display("FAIL fifo_rand_valid[%0d] got %b exp %b", n, bus.tx_valid, q.size() != 0); end
            if (q.size() != 0) begin
                n_vec++; if (bus.tx_data !== q[0]) begin n_err++; $display("FAIL fifo_rand_data[%0d] got %h exp %h", n, bus.tx_data, q[0]); end
            end
            if (rdy && q.size() != 0) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(b);
                else ovf = 1'b1;
            end
        end
        next_cycle();
        bus.tx_ready = 1'b0;
        exp_s = (q.size() << 8) | (32'(ovf) << 2) | ((q.size() == 0) ? 32'h2 : 32'h0) | ((q.size() == DEPTH) ? 32'h1 : 32'h0);
        read_now(STAT, v);
        n_vec++; if (v !== exp_s) begin n_err++; $display("FAIL fifo_rand_status got %h exp %h", v, exp_s); end
        next_cycle();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < DEPTH && q.size() != 0; i++) begin
            if (i > 0) next_cycle();
            #1;
            b = q.pop_front();
            n_vec++; if (bus.tx_data !== b) begin n_err++; $display("FAIL fifo_rand_drain[%0d] got %h exp %h", i, bus.tx_data, b); end
        end
        next_cycle();
        #1;
        n_vec++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL fifo_rand_end got %b exp 0", bus.tx_valid); end
        write_reg(STAT, 32'h0);
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_cycle();
        logic [31:0] v;
        logic [31:0] exp_c [3];
        logic [31:0] r;
        exp_c[0] = 32'hFFFF_FFFE;
        exp_c[1] = 32'hFFFF_FFFF;
        exp_c[2] = 32'h0000_0000;
        write_reg(CYC, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            read_now(CYC, v);
            n_vec++; if (v !== exp_c[i]) begin n_err++; $display("FAIL cycle_wrap[%0d] got %h exp %h", i, v, exp_c[i]); end
        end
        r = $urandom;
        write_reg(CYC, r);
        repeat (4) next_cycle();
        read_now(CYC, v);
        n_vec++; if (v !== r + 32'd3) begin n_err++; $display("FAIL cycle_load got %h exp %h", v, r + 32'd3); end
    endtask

    task automatic test_timer();
        logic [31:0] c;
        logic [31:0] v;
        next_cycle();
        read_now(CYC, c);
        write_reg(CMPR, c + 32'd5);
        write_reg(CTRL, 32'h1);
        for (int n = 3; n <= 8; n++) begin
            next_cycle();
            #1;
            n_vec++; if (timer_irq !== (n >= 6)) begin n_err++; $display("FAIL timer_rise[n=%0d] got %b exp %b", n, timer_irq, n >= 6); end
        end
        write_reg(CTRL, 32'h3);
        next_cycle();
        #1;
        n_vec++; if (timer_irq !== 1'b0) begin n_err++; $display("FAIL timer_clear got %b exp 0", timer_irq); end
        read_now(CTRL, v);
        n_vec++; if (v !== 32'h1) begin n_err++; $display("FAIL timer_ctrl_after_clr got %h exp 1", v); end
        next_cycle();
        read_now(CYC, c);
        write_reg(CMPR, c + 32'd4);
        next_cycle();
        next_cycle();
        write_reg(CTRL, 32'h3);
        #1;
        n_vec++; if (timer_irq !== 1'b0) begin n_err++; $display("FAIL timer_pre_race got %b exp 0", timer_irq); end
        next_cycle();
        #1;
        n_vec++; if (timer_irq !== 1'b1) begin n_err++; $display("FAIL timer_set_wins got %b exp 1", timer_irq); end
        read_now(CTRL, v);
        n_vec++; if (v !== 32'h3) begin n_err++; $display("FAIL timer_ctrl_set got %h exp 3", v); end
        write_reg(CMPR, c);
        next_cycle();
        #1;
        n_vec++; if (timer_irq !== 1'b1) begin n_err++; $display("FAIL timer_cmp_wr_keeps got %b exp 1", timer_irq); end
        write_reg(CTRL, 32'h2);
        next_cycle();
        #1;
        n_vec++; if (timer_irq !== 1'b0) begin n_err++; $display("FAIL timer_disable got %b exp 0", timer_irq); end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_reg(TXD, 32'h61 + i);
        write_reg(CTRL, 32'h1);
        next_cycle();
        bus.tx_ready = 1'b1;
        next_cycle();
        bus.tx_ready = 1'b1;
        #2;
        n_vec++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h62) begin n_err++; $display("FAIL arst_pre got v=%b d=%h exp v=1 d=62", bus.tx_valid, bus.tx_data); end
        RST = 1'b0;
        #1;
        n_vec++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin n_err++; $display("FAIL arst_immediate got v=%b d=%h exp v=0 d=00", bus.tx_valid, bus.tx_data); end
        @(negedge CLK);
        set_bus(1'b0, 1'b1, 32'h20, 32'hBAD0_BAD0);
        @(negedge CLK);
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
        bus.tx_ready = 1'b0;
        RST = 1'b1;
        read_now(STAT, v);
        n_vec++; if (v !== 32'h0002) begin n_err++; $display("FAIL arst_status got %h exp 00000002", v); end
        read_now(CYC, v);
        n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL arst_cycle0 got %h exp 0", v); end
        read_now(CTRL, v);
        n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL arst_ctrl got %h exp 0", v); end
        read_now(32'h20, v);
        n_vec++; if (v !== 32'h1111_1111) begin n_err++; $display("FAIL arst_ram_wr_dropped got %h exp 11111111", v); end
        n_vec++; if (timer_irq !== 1'b0) begin n_err++; $display("FAIL arst_irq got %b exp 0", timer_irq); end
        next_cycle();
        read_now(CYC, v);
        n_vec++; if (v !== 32'h1) begin n_err++; $display("FAIL arst_cycle1 got %h exp 1", v); end
    endtask

    initial begin
        bus.tx_ready = 1'b0;
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_ram_directed();
        test_fifo_overflow();
        test_full_push_pop();
        test_fifo_random();
        test_cycle();
        test_timer();
        test_async_reset();
        test_ram_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
